// File: rtl/matmul_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : matmul_tile_scheduler
// Brief   : Clocked sequencer for the systolic matmul datapath; walks the
//           output tile grid, addresses the BRAM pair, hands tiles downstream.
// Revision: 1.0 - initial release
// ============================================================================
module matmul_tile_scheduler #(
  parameter int INNER_DIMENSION   = 4,
  parameter int I_OUTER_DIMENSION = 8,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int BLOCK_SIZE        = 2,
  parameter int NUM_CORES         = 2,
  parameter int ADDR_WIDTH_I      = 14,
  parameter int ADDR_WIDTH_W      = 12,
  localparam int c_K_STEPS    = INNER_DIMENSION / BLOCK_SIZE,
  localparam int c_ROW_GROUPS = I_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES),
  localparam int c_COL_TILES  = W_OUTER_DIMENSION / BLOCK_SIZE,
  localparam int c_ROW_W      = $clog2(c_ROW_GROUPS) + 1,
  localparam int c_COL_W      = $clog2(c_COL_TILES) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    systolic_finish,
  input  logic                    accumulator_done,
  input  logic                    out_ready,
  output logic                    in_enb,
  output logic                    wb_enb,
  output logic [ADDR_WIDTH_I-1:0] in_addrb,
  output logic [ADDR_WIDTH_W-1:0] wb_addrb,
  output logic                    core_en,
  output logic                    core_rst_n,
  output logic                    core_acc_clr,
  output logic                    out_valid,
  output logic [c_ROW_W-1:0]      out_row,
  output logic [c_COL_W-1:0]      out_col,
  output logic                    busy,
  output logic                    done
);

  localparam int c_K_W = $clog2(c_K_STEPS) + 1;

  generate
    if ((INNER_DIMENSION % BLOCK_SIZE) != 0 ||
        (I_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES)) != 0 ||
        (W_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
        c_K_STEPS < 1 || c_ROW_GROUPS < 1 || c_COL_TILES < 1) begin : g_bad_dims
      $error("matmul_tile_scheduler: dimensions do not divide into whole tiles");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_RUN      = 3'd2,
    S_STEP     = 3'd3,
    S_WAIT_ACC = 3'd4,
    S_OUT      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t             r_state;
  logic [c_K_W-1:0]   r_k;
  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] r_col;
  logic               r_acc_seen;

  state_t                  w_state;
  logic [c_K_W-1:0]        w_k;
  logic [c_ROW_W-1:0]      w_row;
  logic [c_COL_W-1:0]      w_col;
  logic                    w_acc_seen;
  logic                    w_last_k;
  logic                    w_last_row;
  logic                    w_last_col;
  logic                    w_busy;
  logic [ADDR_WIDTH_I-1:0] w_in_addr;
  logic [ADDR_WIDTH_W-1:0] w_wb_addr;

  always_comb begin
    w_state    = r_state;
    w_k        = r_k;
    w_row      = r_row;
    w_col      = r_col;
    w_acc_seen = r_acc_seen;
    w_last_k   = (r_k == c_K_W'(c_K_STEPS - 1));
    w_last_row = (r_row == c_ROW_W'(c_ROW_GROUPS - 1));
    w_last_col = (r_col == c_COL_W'(c_COL_TILES - 1));

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state    = S_ISSUE;
          w_k        = '0;
          w_row      = '0;
          w_col      = '0;
          w_acc_seen = 1'b0;
        end
      end
      S_ISSUE: w_state = S_RUN;
      S_RUN: begin
        if (accumulator_done) w_acc_seen = 1'b1;
        if (systolic_finish)  w_state    = S_STEP;
      end
      S_STEP: begin
        if (accumulator_done) w_acc_seen = 1'b1;
        if (!w_last_k) begin
          w_k     = r_k + 1'b1;
          w_state = S_ISSUE;
        end else begin
          w_state = S_WAIT_ACC;
        end
      end
      S_WAIT_ACC: begin
        // A completion captured earlier still releases the tile immediately
        if (r_acc_seen || accumulator_done) begin
          w_state    = S_OUT;
          w_acc_seen = 1'b0;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_k = '0;
          if (w_last_col) begin
            w_col = '0;
            w_row = w_last_row ? '0 : r_row + 1'b1;
          end else begin
            w_col = r_col + 1'b1;
          end
          w_state = (w_last_row && w_last_col) ? S_DONE : S_ISSUE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_busy    = (w_state != S_IDLE) && (w_state != S_DONE);
    w_in_addr = ADDR_WIDTH_I'(w_k) + ADDR_WIDTH_I'(c_K_STEPS) * ADDR_WIDTH_I'(w_row);
    w_wb_addr = ADDR_WIDTH_W'(w_k) + ADDR_WIDTH_W'(c_K_STEPS) * ADDR_WIDTH_W'(w_col);
  end

  // Outputs are decoded from the next state so they change together with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_acc_seen   <= 1'b0;
      in_enb       <= 1'b0;
      wb_enb       <= 1'b0;
      in_addrb     <= '0;
      wb_addrb     <= '0;
      core_en      <= 1'b0;
      core_rst_n   <= 1'b0;
      core_acc_clr <= 1'b0;
      out_valid    <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_k          <= w_k;
      r_row        <= w_row;
      r_col        <= w_col;
      r_acc_seen   <= w_acc_seen;
      in_enb       <= (w_state == S_ISSUE) || (w_state == S_RUN);
      wb_enb       <= (w_state == S_ISSUE) || (w_state == S_RUN);
      in_addrb     <= w_busy ? w_in_addr : '0;
      wb_addrb     <= w_busy ? w_wb_addr : '0;
      core_en      <= (w_state == S_RUN);
      core_rst_n   <= (w_state == S_ISSUE) || (w_state == S_RUN);
      core_acc_clr <= (w_state == S_ISSUE) && (w_k == '0);
      out_valid    <= (w_state == S_OUT);
      out_row      <= w_busy ? w_row : '0;
      out_col      <= w_busy ? w_col : '0;
      busy         <= w_busy;
      done         <= (w_state == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_matmul_tile_scheduler
// Brief   : Directed scoreboard bench for matmul_tile_scheduler (K=2 and K=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_matmul_tile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n2, sel;
  logic start, systolic_finish, accumulator_done, out_ready;

  logic        in_enb1, wb_enb1, core_en1, core_rst_n1, core_acc_clr1, out_valid1, busy1, done1;
  logic [13:0] in_addrb1;
  logic [11:0] wb_addrb1;
  logic [1:0]  out_row1;
  logic [2:0]  out_col1;
  logic        in_enb2, wb_enb2, core_en2, core_rst_n2, core_acc_clr2, out_valid2, busy2, done2;
  logic [13:0] in_addrb2;
  logic [11:0] wb_addrb2;
  logic [1:0]  out_row2;
  logic [2:0]  out_col2;

  matmul_tile_scheduler u_dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start), .systolic_finish(systolic_finish),
    .accumulator_done(accumulator_done), .out_ready(out_ready),
    .in_enb(in_enb1), .wb_enb(wb_enb1), .in_addrb(in_addrb1), .wb_addrb(wb_addrb1),
    .core_en(core_en1), .core_rst_n(core_rst_n1), .core_acc_clr(core_acc_clr1),
    .out_valid(out_valid1), .out_row(out_row1), .out_col(out_col1),
    .busy(busy1), .done(done1)
  );

  matmul_tile_scheduler #(.INNER_DIMENSION(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start), .systolic_finish(systolic_finish),
    .accumulator_done(accumulator_done), .out_ready(out_ready),
    .in_enb(in_enb2), .wb_enb(wb_enb2), .in_addrb(in_addrb2), .wb_addrb(wb_addrb2),
    .core_en(core_en2), .core_rst_n(core_rst_n2), .core_acc_clr(core_acc_clr2),
    .out_valid(out_valid2), .out_row(out_row2), .out_col(out_col2),
    .busy(busy2), .done(done2)
  );

  logic        in_enb, wb_enb, core_en, core_rst_n, core_acc_clr, out_valid, busy, done;
  logic [13:0] in_addrb;
  logic [11:0] wb_addrb;
  logic [1:0]  out_row;
  logic [2:0]  out_col;
  assign in_enb       = sel ? in_enb2       : in_enb1;
  assign wb_enb       = sel ? wb_enb2       : wb_enb1;
  assign core_en      = sel ? core_en2      : core_en1;
  assign core_rst_n   = sel ? core_rst_n2   : core_rst_n1;
  assign core_acc_clr = sel ? core_acc_clr2 : core_acc_clr1;
  assign out_valid    = sel ? out_valid2    : out_valid1;
  assign busy         = sel ? busy2         : busy1;
  assign done         = sel ? done2         : done1;
  assign in_addrb     = sel ? in_addrb2     : in_addrb1;
  assign wb_addrb     = sel ? wb_addrb2     : wb_addrb1;
  assign out_row      = sel ? out_row2      : out_row1;
  assign out_col      = sel ? out_col2      : out_col1;

  int total = 0;
  int bad   = 0;
  int sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {in_enb, wb_enb, core_en, core_rst_n, core_acc_clr, out_valid, busy, done}, 32'h0);
    chk({tag, "_addr"}, {in_addrb, wb_addrb}, 32'h0);
    chk({tag, "_tile"}, {out_row, out_col}, 32'h0);
  endtask

  // One tile: enters in ISSUE of k=0, leaves one cycle after the handshake
  task automatic run_tile(input int ks, input int row, input int col,
                          input bit acc_early, input int hold, input bit poke_start);
    logic [31:0] exp_tile;
    logic [25:0] addr_snap;
    for (int k = 0; k < ks; k++) begin
      chk("issue_ctl", {in_enb, wb_enb, core_en, core_rst_n, busy, out_valid}, 6'b110110);
      chk("issue_clr", core_acc_clr, (k == 0));
      chk("issue_in_addr", in_addrb, k + ks * row);
      chk("issue_wb_addr", wb_addrb, k + ks * col);
      step();
      chk("run_ctl", {in_enb, wb_enb, core_en, core_rst_n, core_acc_clr}, 5'b11110);
      chk("run_addr", {in_addrb, wb_addrb}, {14'(k + ks * row), 12'(k + ks * col)});
      if (poke_start && k == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored", {core_en, busy, done, core_acc_clr}, 4'b1100);
        chk("start_ignored_addr", {in_addrb, wb_addrb}, {14'(ks * row), 12'(ks * col)});
      end
      for (int i = 0; i < 4; i++) step();
      systolic_finish = 1'b1;
      if (acc_early && k == ks - 1) accumulator_done = 1'b1;
      step();
      systolic_finish  = 1'b0;
      accumulator_done = 1'b0;
      chk("step_ctl", {core_en, core_rst_n, out_valid}, 3'b000);
      step();
    end
    chk("wait_ctl", {in_enb, wb_enb, core_en, out_valid}, 4'b0000);
    if (hold > 0) out_ready = 1'b0;
    if (!acc_early) accumulator_done = 1'b1;
    step();
    accumulator_done = 1'b0;
    exp_tile = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'hdead;
    chk("out_valid", out_valid, 1'b1);
    chk("out_tile", {out_row, out_col}, exp_tile);
    addr_snap = {in_addrb, wb_addrb};
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_tile", {out_row, out_col}, exp_tile);
      chk("bp_addr", {in_addrb, wb_addrb}, addr_snap);
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_valid", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n1 = 1'b0; rst_n2 = 1'b0; sel = 1'b0;
    start = 1'b0; systolic_finish = 1'b0; accumulator_done = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk_reset("reset");
    rst_n1 = 1'b1;
    step();
    chk_reset("idle_hold");

    // Full pass: start poke during (0,0), backpressure on (0,1), early acc on (0,2)
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) sb.push_back(r * 8 + c);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", {busy, done}, 2'b10);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        run_tile(2, r, c, (r == 0 && c == 2), (r == 0 && c == 1) ? 10 : 0, (r == 0 && c == 0));
    chk("done_set", {done, busy, out_valid, in_enb, core_rst_n}, 5'b10000);
    chk("done_addr", {in_addrb, wb_addrb}, 32'h0);
    chk("sb_empty", sb.size(), 0);
    step();
    step();
    chk("done_sticky", done, 1'b1);

    // Restart after done, then reset in the middle of tile (1,1)
    for (int t = 0; t < 4; t++) sb.push_back((t / 3) * 8 + (t % 3));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_flags", {done, busy}, 2'b01);
    chk("restart_addr", {in_addrb, wb_addrb}, 32'h0);
    for (int t = 0; t < 4; t++) run_tile(2, t / 3, t % 3, 1'b0, 0, 1'b0);
    step();
    step();
    chk("mid_run_11", {core_en, in_addrb, wb_addrb}, {1'b1, 14'd2, 12'd2});
    rst_n1 = 1'b0;
    step();
    rst_n1 = 1'b1;
    chk_reset("mid_reset");
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_idle", {busy, out_valid, in_enb, core_en, done}, 5'b00000);
    end

    // K_STEPS = 1 instance
    rst_n1 = 1'b0;
    sel    = 1'b1;
    rst_n2 = 1'b1;
    step();
    chk_reset("k1_idle");
    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) sb.push_back(r * 8 + c);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        run_tile(1, r, c, (r == 1 && c == 0), 0, 1'b0);
    chk("k1_done", {done, busy}, 2'b10);
    chk("k1_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
